// File: rtl/nested_addr_gen_pkg.sv
// Shared widths, gap-mode encoding and FSM state type for the nested address generator.
package nested_addr_gen_pkg;

    localparam int unsigned ADDR_W_DEF   = 10;
    localparam int unsigned PERIOD_W_DEF = 10;

    typedef enum logic {
        GAP_HOLD   = 1'b0,
        GAP_BUBBLE = 1'b1
    } gap_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/nested_addr_gen_if.sv
// Configuration, run/ready handshake and address stream of the nested address generator.
interface nested_addr_gen_if #(
    parameter int unsigned ADDR_W   = nested_addr_gen_pkg::ADDR_W_DEF,
    parameter int unsigned PERIOD_W = nested_addr_gen_pkg::PERIOD_W_DEF
);
    logic                run;
    logic [ADDR_W-1:0]   iterations;
    logic [ADDR_W-1:0]   iterations2;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] duty;
    logic [PERIOD_W-1:0] delay;
    logic [ADDR_W-1:0]   start;
    logic [ADDR_W-1:0]   incr;
    logic [ADDR_W-1:0]   shift;
    logic [ADDR_W-1:0]   shift2;
    logic                gap_mode;
    logic                ready;
    logic                valid;
    logic [ADDR_W-1:0]   addr;
    logic                done;

    // Address generator side
    modport master (
        input  run, iterations, iterations2, period, duty, delay,
               start, incr, shift, shift2, gap_mode, ready,
        output valid, addr, done
    );

    // Controller / consumer side
    modport slave (
        output run, iterations, iterations2, period, duty, delay,
               start, incr, shift, shift2, gap_mode, ready,
        input  valid, addr, done
    );
endinterface

// File: rtl/nested_addr_gen_loop_cnt.sv
// Loop counter with clear/increment and an end flag that cannot wrap at the maximum count.
module addr_gen_loop_cnt #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         last_c
);
    // Registered count; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

    // Compare at W+1 bits so count+1 never wraps; a limit of 0 ends like a limit of 1
    assign last_c = (({1'b0, count} + (W+1)'(1)) >= {1'b0, limit});
endmodule

// File: rtl/nested_addr_gen.sv
// Three-level nested address generator with start delay, duty cycle and ready backpressure.
module nested_addr_gen
    import nested_addr_gen_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned PERIOD_W = PERIOD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    nested_addr_gen_if.master bus
);
    state_e              state;
    gap_mode_e           gap_q;
    logic                valid_q;
    logic                done_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   incr_q;
    logic [ADDR_W-1:0]   shift_q;
    logic [ADDR_W-1:0]   shift2_q;
    logic [ADDR_W-1:0]   iterations_q;
    logic [ADDR_W-1:0]   iterations2_q;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] duty_q;
    logic [PERIOD_W-1:0] delay_cnt;

    logic [PERIOD_W-1:0] per_cnt;
    logic [ADDR_W-1:0]   iter_cnt;
    logic [ADDR_W-1:0]   iter2_cnt;
    logic                p_end, i_end, o_end;
    logic                advance;
    logic                per_clr, per_inc, iter_clr, iter_inc, iter2_clr, iter2_inc;
    logic [PERIOD_W-1:0] per_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic                gap_nxt;
    logic                gap_at_start;
    logic                unused_counts;

    addr_gen_loop_cnt #(.W(PERIOD_W)) u_per (
        .clk(clk), .rst(rst), .clr(per_clr), .inc(per_inc),
        .limit(period_q), .count(per_cnt), .last_c(p_end)
    );

    addr_gen_loop_cnt #(.W(ADDR_W)) u_iter (
        .clk(clk), .rst(rst), .clr(iter_clr), .inc(iter_inc),
        .limit(iterations_q), .count(iter_cnt), .last_c(i_end)
    );

    addr_gen_loop_cnt #(.W(ADDR_W)) u_iter2 (
        .clk(clk), .rst(rst), .clr(iter2_clr), .inc(iter2_inc),
        .limit(iterations2_q), .count(iter2_cnt), .last_c(o_end)
    );

    // Outer loop counts are only consumed through their end flags
    assign unused_counts = ^{iter_cnt, iter2_cnt};

    // Step decode: a step is a beat, or any cycle spent inside a bubble gap
    always_comb begin
        advance   = 1'b0;
        addr_nxt  = addr_q;
        if (state == ST_RUN) begin
            advance = valid_q ? bus.ready : (gap_q == GAP_BUBBLE);
        end
        per_clr   = bus.run | (advance & p_end);
        per_inc   = advance & ~p_end;
        iter_clr  = bus.run | (advance & p_end & i_end);
        iter_inc  = advance & p_end & ~i_end;
        iter2_clr = bus.run;
        iter2_inc = advance & p_end & i_end & ~o_end;
        per_nxt   = p_end ? '0 : per_cnt + PERIOD_W'(1);
        gap_nxt   = (gap_q == GAP_BUBBLE) && (per_nxt >= duty_q);
        gap_at_start = (gap_q == GAP_BUBBLE) && (duty_q == '0);
        if (!p_end) begin
            if (per_cnt < duty_q) begin
                addr_nxt = addr_q + incr_q;
            end
        end else if (!i_end) begin
            addr_nxt = addr_q + shift_q;
        end else begin
            addr_nxt = addr_q + shift_q + shift2_q;
        end
    end

    // Sequencer: run loads and restarts, delay countdown, stepping, completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            gap_q         <= GAP_HOLD;
            valid_q       <= 1'b0;
            done_q        <= 1'b0;
            addr_q        <= '0;
            incr_q        <= '0;
            shift_q       <= '0;
            shift2_q      <= '0;
            iterations_q  <= '0;
            iterations2_q <= '0;
            period_q      <= '0;
            duty_q        <= '0;
            delay_cnt     <= '0;
        end else if (bus.run) begin
            gap_q         <= gap_mode_e'(bus.gap_mode);
            incr_q        <= bus.incr;
            shift_q       <= bus.shift;
            shift2_q      <= bus.shift2;
            iterations_q  <= bus.iterations;
            iterations2_q <= bus.iterations2;
            period_q      <= bus.period;
            duty_q        <= bus.duty;
            delay_cnt     <= bus.delay;
            addr_q        <= bus.start;
            done_q        <= 1'b0;
            if (bus.delay == '0) begin
                state   <= ST_RUN;
                valid_q <= !(bus.gap_mode && (bus.duty == '0));
            end else begin
                state   <= ST_DELAY;
                valid_q <= 1'b0;
            end
        end else begin
            case (state)
                ST_DELAY: begin
                    if (delay_cnt <= PERIOD_W'(1)) begin
                        delay_cnt <= '0;
                        state     <= ST_RUN;
                        valid_q   <= !gap_at_start;
                    end else begin
                        delay_cnt <= delay_cnt - PERIOD_W'(1);
                    end
                end
                ST_RUN: begin
                    if (advance) begin
                        if (p_end && i_end && o_end) begin
                            state   <= ST_DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q  <= addr_nxt;
                            valid_q <= !gap_nxt;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.valid = valid_q;
    assign bus.addr  = addr_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_nested_addr_gen.sv
// Scoreboard bench for nested_addr_gen: a loop-nest model queues expected addresses, a monitor pops them on beats.
module tb_nested_addr_gen;
    localparam int unsigned AW = 10;
    localparam int unsigned PW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    nested_addr_gen_if #(.ADDR_W(AW), .PERIOD_W(PW)) bus ();
    nested_addr_gen #(.ADDR_W(AW), .PERIOD_W(PW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] c_start, c_incr, c_shift, c_shift2, c_iter, c_iter2;
    logic [PW-1:0] c_period, c_duty, c_delay;
    logic          c_gap;

    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] obs_q[$];
    int            beat_cnt = 0;
    int            last_beat_cyc = 0;
    int            run_cyc = 0;
    bit            mon_en = 1'b1;
    bit            stalled = 1'b0;
    logic [AW-1:0] stall_addr;

    logic [AW-1:0] basic_tab [16] = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd3, 10'd4, 10'd5, 10'd6,
                                      10'd14, 10'd15, 10'd16, 10'd17, 10'd17, 10'd18, 10'd19, 10'd20};
    logic [AW-1:0] gap_tab [6] = '{10'd0, 10'd1, 10'd12, 10'd13, 10'd24, 10'd25};

    // Monitor: pop and compare on every beat, check addr holds across stalls
    initial begin
        logic [AW-1:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (stalled && bus.valid) begin
                    n_checks++;
                    if (bus.addr !== stall_addr) begin
                        n_fail++;
                        $display("FAIL hold_addr: addr=%0d required=%0d", bus.addr, stall_addr);
                    end
                end
                stalled    = bus.valid && !bus.ready;
                stall_addr = bus.addr;
                if (bus.valid && bus.ready) begin
                    beat_cnt++;
                    last_beat_cyc = cyc;
                    obs_q.push_back(bus.addr);
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_beat: addr=%0d required=no beat", bus.addr);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.addr !== e) begin
                            n_fail++;
                            $display("FAIL beat_addr: addr=%0d required=%0d", bus.addr, e);
                        end
                    end
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic set_cfg(input logic [AW-1:0] st, input logic [AW-1:0] inc,
                           input logic [AW-1:0] sh, input logic [AW-1:0] sh2,
                           input logic [AW-1:0] it, input logic [AW-1:0] it2,
                           input logic [PW-1:0] per, input logic [PW-1:0] dut_y,
                           input logic [PW-1:0] dly, input logic gap);
        c_start = st; c_incr = inc; c_shift = sh; c_shift2 = sh2;
        c_iter = it; c_iter2 = it2; c_period = per; c_duty = dut_y;
        c_delay = dly; c_gap = gap;
    endtask

    // Reference: plain nested loops over the configured counts
    task automatic push_model();
        int np = (c_period == '0) ? 1 : int'(c_period);
        int ni = (c_iter == '0) ? 1 : int'(c_iter);
        int no = (c_iter2 == '0) ? 1 : int'(c_iter2);
        int du = int'(c_duty);
        logic [AW-1:0] a = c_start;
        for (int o = 0; o < no; o++) begin
            for (int i = 0; i < ni; i++) begin
                for (int p = 0; p < np; p++) begin
                    if (!c_gap || p < du) exp_q.push_back(a);
                    if (p < np - 1) begin
                        if (p < du) a = a + c_incr;
                    end else if (i < ni - 1) begin
                        a = a + c_shift;
                    end else if (o < no - 1) begin
                        a = a + c_shift + c_shift2;
                    end
                end
            end
        end
    endtask

    // Drive config, queue expectations, pulse run, then scramble config
    task automatic launch();
        bus.start = c_start; bus.incr = c_incr; bus.shift = c_shift; bus.shift2 = c_shift2;
        bus.iterations = c_iter; bus.iterations2 = c_iter2; bus.period = c_period;
        bus.duty = c_duty; bus.delay = c_delay; bus.gap_mode = c_gap;
        push_model();
        obs_q.delete();
        beat_cnt = 0;
        bus.run = 1'b1;
        @(posedge clk); #1;
        bus.run = 1'b0;
        run_cyc = cyc;
        bus.start = 10'h155; bus.incr = 10'h2AA; bus.shift = 10'h0F0; bus.shift2 = 10'h30F;
        bus.iterations = 10'd7; bus.iterations2 = 10'd9; bus.period = 10'd1;
        bus.duty = 10'd0; bus.delay = 10'd5; bus.gap_mode = ~c_gap;
    endtask

    task automatic wait_done(input bit bp, input int budget,
                             output int first_v, output int done_at, output int bubbles);
        first_v = -1; done_at = -1; bubbles = 0;
        for (int k = 0; k < budget; k++) begin
            if (first_v < 0 && bus.valid) first_v = cyc - run_cyc;
            if (bus.done) begin
                done_at = cyc - run_cyc;
                break;
            end
            if (first_v >= 0 && !bus.valid) bubbles++;
            if (bp) bus.ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        bus.ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got=%0b want=0", bus.valid); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got=%0b want=0", bus.done); end
        n_checks++; if (bus.addr !== '0) begin n_fail++; $display("FAIL reset_addr: got=%0d want=0", bus.addr); end
        rst = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        n_checks++;
        if (bus.valid !== 1'b0 || bus.done !== 1'b0 || beat_cnt != 0) begin
            n_fail++; $display("FAIL idle_after_reset: valid=%0b done=%0b beats=%0d want 0/0/0", bus.valid, bus.done, beat_cnt);
        end
    endtask

    task automatic test_basic();
        int fv, da, bb;
        set_cfg(10'd0, 10'd1, 10'd0, 10'd8, 10'd2, 10'd2, 10'd4, 10'd4, 10'd0, 1'b0);
        launch();
        wait_done(1'b0, 200, fv, da, bb);
        n_checks++; if (fv != 0) begin n_fail++; $display("FAIL basic_first_valid: cycle=%0d want=0", fv); end
        n_checks++; if (da < 0) begin n_fail++; $display("FAIL basic_timeout: done never rose, want done"); end
        n_checks++; if (beat_cnt != 16) begin n_fail++; $display("FAIL basic_beats: got=%0d want=16", beat_cnt); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_leftover: got=%0d want=0", exp_q.size()); end
        n_checks++;
        if (da != last_beat_cyc - run_cyc + 1) begin
            n_fail++; $display("FAIL basic_done_timing: done_at=%0d want=%0d", da, last_beat_cyc - run_cyc + 1);
        end
        for (int k = 0; k < 16 && k < obs_q.size(); k++) begin
            n_checks++;
            if (obs_q[k] !== basic_tab[k]) begin
                n_fail++; $display("FAIL basic_seq[%0d]: got=%0d want=%0d", k, obs_q[k], basic_tab[k]);
            end
        end
    endtask

    task automatic test_delay();
        int fv, da, bb;
        set_cfg(10'd50, 10'd1, 10'd0, 10'd0, 10'd1, 10'd1, 10'd4, 10'd4, 10'd3, 1'b0);
        launch();
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL delay_done_clear: got=%0b want=0", bus.done); end
        wait_done(1'b0, 200, fv, da, bb);
        n_checks++; if (fv != 3) begin n_fail++; $display("FAIL delay_first_valid: cycle=%0d want=3", fv); end
        n_checks++; if (da < 0 || beat_cnt != 4) begin n_fail++; $display("FAIL delay_beats: beats=%0d done_at=%0d want 4 beats and done", beat_cnt, da); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL delay_leftover: got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_gap();
        int fv, da, bb;
        set_cfg(10'd0, 10'd1, 10'd10, 10'd0, 10'd3, 10'd1, 10'd4, 10'd2, 10'd0, 1'b1);
        launch();
        wait_done(1'b0, 200, fv, da, bb);
        n_checks++; if (da < 0) begin n_fail++; $display("FAIL gap_timeout: done never rose, want done"); end
        n_checks++; if (beat_cnt != 6) begin n_fail++; $display("FAIL gap_beats: got=%0d want=6", beat_cnt); end
        n_checks++; if (bb != 6) begin n_fail++; $display("FAIL gap_bubbles: got=%0d want=6", bb); end
        n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL gap_end_valid: got=%0b want=0", bus.valid); end
        for (int k = 0; k < 6 && k < obs_q.size(); k++) begin
            n_checks++;
            if (obs_q[k] !== gap_tab[k]) begin
                n_fail++; $display("FAIL gap_seq[%0d]: got=%0d want=%0d", k, obs_q[k], gap_tab[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        int fv, da, bb;
        set_cfg(10'd0, 10'd1, 10'd0, 10'd8, 10'd2, 10'd2, 10'd4, 10'd4, 10'd0, 1'b0);
        launch();
        wait_done(1'b1, 400, fv, da, bb);
        n_checks++; if (da < 0) begin n_fail++; $display("FAIL bp_timeout: done never rose, want done"); end
        n_checks++; if (beat_cnt != 16) begin n_fail++; $display("FAIL bp_beats: got=%0d want=16", beat_cnt); end
        for (int k = 0; k < 16 && k < obs_q.size(); k++) begin
            n_checks++;
            if (obs_q[k] !== basic_tab[k]) begin
                n_fail++; $display("FAIL bp_seq[%0d]: got=%0d want=%0d", k, obs_q[k], basic_tab[k]);
            end
        end
    endtask

    task automatic test_boundaries();
        int fv, da, bb;
        // zero outer counts behave as one
        set_cfg(10'd4, 10'd1, 10'd100, 10'd7, 10'd0, 10'd0, 10'd2, 10'd2, 10'd0, 1'b0);
        launch();
        wait_done(1'b0, 100, fv, da, bb);
        n_checks++; if (da < 0 || beat_cnt != 2) begin n_fail++; $display("FAIL zero_counts: beats=%0d done_at=%0d want 2 beats and done", beat_cnt, da); end
        // address wraps modulo 2^ADDR_W
        set_cfg(10'h3FF, 10'd1, 10'd0, 10'd0, 10'd1, 10'd1, 10'd3, 10'd3, 10'd0, 1'b0);
        launch();
        wait_done(1'b0, 100, fv, da, bb);
        n_checks++;
        if (da < 0 || obs_q.size() != 3 || obs_q[1] !== 10'd0) begin
            n_fail++; $display("FAIL addr_wrap: beats=%0d second=%0d want 3 beats second=0", obs_q.size(), (obs_q.size() > 1) ? obs_q[1] : 10'd0);
        end
        // duty 0 in hold mode only moves at loop ends
        set_cfg(10'd7, 10'd1, 10'd5, 10'd0, 10'd2, 10'd1, 10'd3, 10'd0, 10'd0, 1'b0);
        launch();
        wait_done(1'b0, 100, fv, da, bb);
        n_checks++;
        if (da < 0 || obs_q.size() != 6 || obs_q[2] !== 10'd7 || obs_q[3] !== 10'd12) begin
            n_fail++; $display("FAIL duty_zero: beats=%0d want 6 with addr 7,7,7,12,12,12", obs_q.size());
        end
        // negative steps
        set_cfg(10'd5, 10'h3FF, 10'h3FD, 10'h3F6, 10'd2, 10'd2, 10'd3, 10'd3, 10'd0, 1'b0);
        launch();
        wait_done(1'b0, 100, fv, da, bb);
        n_checks++;
        if (da < 0 || obs_q.size() != 12 || obs_q[11] !== 10'd1002) begin
            n_fail++; $display("FAIL neg_steps: beats=%0d last=%0d want 12 beats last=1002", obs_q.size(), (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 10'd0);
        end
        // maximum period completes without counter wrap
        set_cfg(10'd0, 10'd1, 10'd0, 10'd0, 10'd1, 10'd1, 10'h3FF, 10'h3FF, 10'd0, 1'b0);
        launch();
        wait_done(1'b0, 2000, fv, da, bb);
        n_checks++;
        if (da < 0 || beat_cnt != 1023 || obs_q.size() == 0 || obs_q[obs_q.size()-1] !== 10'd1022) begin
            n_fail++; $display("FAIL max_period: beats=%0d done_at=%0d want 1023 beats ending at 1022", beat_cnt, da);
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bound_leftover: got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_abort();
        int fv, da, bb;
        set_cfg(10'd0, 10'd1, 10'd0, 10'd8, 10'd2, 10'd2, 10'd4, 10'd4, 10'd0, 1'b0);
        launch();
        repeat (5) begin @(posedge clk); #1; end
        // restart mid-sequence from a new start
        mon_en = 1'b0;
        exp_q.delete();
        c_start = 10'd100;
        launch();
        n_checks++; if (bus.addr !== 10'd100) begin n_fail++; $display("FAIL abort_run_addr: got=%0d want=100", bus.addr); end
        n_checks++; if (bus.valid !== 1'b1 || bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_run_flags: valid=%0b done=%0b want 1/0", bus.valid, bus.done); end
        mon_en = 1'b1;
        wait_done(1'b0, 200, fv, da, bb);
        n_checks++; if (da < 0 || beat_cnt != 16) begin n_fail++; $display("FAIL abort_run_beats: beats=%0d done_at=%0d want 16 and done", beat_cnt, da); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL abort_leftover: got=%0d want=0", exp_q.size()); end
        // reset mid-sequence clears outputs without a clock edge
        c_start = 10'd300;
        launch();
        repeat (3) begin @(posedge clk); #1; end
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.valid !== 1'b0 || bus.done !== 1'b0 || bus.addr !== '0) begin
            n_fail++; $display("FAIL abort_rst: valid=%0b done=%0b addr=%0d want 0/0/0", bus.valid, bus.done, bus.addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        repeat (4) begin @(posedge clk); #1; end
        n_checks++;
        if (bus.valid !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL abort_rst_idle: valid=%0b done=%0b want 0/0", bus.valid, bus.done);
        end
        mon_en = 1'b1;
    endtask

    initial begin
        bus.run = 1'b0; bus.ready = 1'b1; bus.gap_mode = 1'b0;
        bus.start = '0; bus.incr = '0; bus.shift = '0; bus.shift2 = '0;
        bus.iterations = '0; bus.iterations2 = '0;
        bus.period = '0; bus.duty = '0; bus.delay = '0;
        test_reset();
        test_basic();
        test_delay();
        test_gap();
        test_backpressure();
        test_boundaries();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
